// File: rtl/shared_bus_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin shared-bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } arb_state_e;

  // Turnaround is limited to 0..3 idle cycles, so two bits always suffice.
  localparam int TA_CNT_W = 2;

  // ID_W helper: width of an index into n items, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_if.sv
// Requester-side handshake bundle of the shared-bus arbiter. The resolved bus
// net itself stays a plain inout of the arbiter.
interface shared_bus_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int ID_W = bus_arb_pkg::id_w(N);

  logic [N-1:0]    req;
  logic [N*W-1:0]  wdata;
  logic [N-1:0]    grant;
  logic            bus_valid;
  logic [ID_W-1:0] owner_id;
  logic            contention_err;

  modport master (
    output req, wdata,
    input  grant, bus_valid, owner_id, contention_err
  );

  modport slave (
    input  req, wdata,
    output grant, bus_valid, owner_id, contention_err
  );

endinterface

// File: rtl/shared_bus_arbiter_rr_pick.sv
// Combinational circular priority picker: first set request at or after ptr.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = id_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            any_o,
  output logic [ID_W-1:0] idx_o
);

  logic [N-1:0] rot;
  logic [ID_W:0] sum;

  // Rotate so that bit 0 of rot corresponds to requester ptr_i.
  assign rot   = N'({req_i, req_i} >> ptr_i);
  assign any_o = |req_i;

  always_comb begin
    sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) sum = {1'b0, ptr_i} + (ID_W + 1)'(k);
    end
    if (sum >= (ID_W + 1)'(N)) sum = sum - (ID_W + 1)'(N);
  end

  assign idx_o = sum[ID_W-1:0];

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter and tri-state driver with programmable turnaround gaps.
// Define CONTENTION_CHK_EN to build the sticky contention checker.
module shared_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 4
) (
  input  logic                clk,
  input  logic                rst,
  shared_bus_arbiter_if.slave bus_if,
  inout  wire  [W-1:0]        bus
);

  localparam int ID_W   = id_w(N);
  localparam int BEAT_W = id_w(MAX_HOLD);
  localparam logic [TA_CNT_W-1:0] TA_LAST =
    TA_CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(N - 1);

  arb_state_e          state_q, state_d;
  logic [N-1:0]        grant_q, grant_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     pend_q, pend_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [TA_CNT_W-1:0] ta_q, ta_d;

  logic            owner_req;
  logic            bus_valid_w;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W-1:0] pick_ptr;
  logic            pick_any;
  logic [ID_W-1:0] pick_idx;
  logic [W-1:0]    drv_data;
  logic            launch;

  assign owner_req   = bus_if.req[owner_q];
  assign bus_valid_w = (state_q == OWN) && owner_req;
  assign next_ptr    = (owner_q == ID_LAST) ? '0 : owner_q + 1'b1;
  // On a release the next owner is searched from the post-release pointer.
  assign pick_ptr    = (state_q == OWN) ? next_ptr : rr_ptr_q;
  assign drv_data    = bus_if.wdata[owner_q*W +: W];

  rr_pick #(.N(N)) u_pick (
    .req_i (bus_if.req),
    .ptr_i (pick_ptr),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      pend_q   <= '0;
      beat_q   <= '0;
      ta_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      pend_q   <= pend_d;
      beat_q   <= beat_d;
      ta_q     <= ta_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    pend_d   = pend_q;
    beat_d   = beat_q;
    ta_d     = ta_q;
    launch   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) launch = 1'b1;
      end
      TURN: begin
        if (ta_q == TA_LAST) begin
          state_d          = OWN;
          grant_d          = '0;
          grant_d[pend_q]  = 1'b1;
          owner_d          = pend_q;
          beat_d           = '0;
        end else begin
          ta_d = ta_q + 1'b1;
        end
      end
      OWN: begin
        if (bus_valid_w) beat_d = beat_q + 1'b1;
        if (!owner_req || (bus_valid_w && (beat_q == BEAT_LAST))) begin
          rr_ptr_d = next_ptr;
          grant_d  = '0;
          state_d  = IDLE;
          if (pick_any) launch = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      if (TURNAROUND == 0) begin
        state_d           = OWN;
        grant_d           = '0;
        grant_d[pick_idx] = 1'b1;
        owner_d           = pick_idx;
        beat_d            = '0;
      end else begin
        state_d = TURN;
        pend_d  = pick_idx;
        ta_d    = '0;
      end
    end
  end

  assign bus              = (state_q == OWN) ? drv_data : {W{1'bz}};
  assign bus_if.grant     = grant_q;
  assign bus_if.owner_id  = owner_q;
  assign bus_if.bus_valid = bus_valid_w;

`ifdef CONTENTION_CHK_EN
  logic err_q, err_d;

  // A read-back differing from what we drive means another driver is fighting us.
  always_comb begin
    err_d = err_q;
    if (($countones(grant_q) > 1) ||
        ((grant_q != '0) && (state_q != OWN)) ||
        (bus_valid_w && (bus !== drv_data)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus_if.contention_err = err_q;
`else
  assign bus_if.contention_err = 1'b0;
`endif

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Self-checking bench for shared_bus_arbiter: ownership model checked every
// cycle plus directed scenarios with hand-computed expectations.
module tb_shared_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TA = 1;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  tri   [W-1:0] bus;

  shared_bus_arbiter_if #(.N(N), .W(W)) u_if ();

  shared_bus_arbiter #(
    .N(N), .W(W), .TURNAROUND(TA), .MAX_HOLD(MH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (u_if),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit ext_en = 1'b0;

`ifdef CONTENTION_CHK_EN
  assign bus = ext_en ? {W{1'b0}} : {W{1'bz}};
`endif

  // Reference model: who holds the bus, who is queued, how long the gap lasts.
  int m_holder = -1;
  int m_next   = -1;
  int m_gap    = 0;
  int m_last   = 0;
  int m_rr     = 0;
  int m_beats  = 0;
  bit m_err    = 1'b0;

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic take();
    m_holder = m_next;
    m_last   = m_next;
    m_next   = -1;
    m_beats  = 0;
  endtask

  task automatic arm();
    if (u_if.req != '0) begin
      m_next = first_from(u_if.req, m_rr);
      m_gap  = TA;
      if (TA == 0) take();
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_holder = -1; m_next = -1; m_gap = 0; m_last = 0;
      m_rr = 0; m_beats = 0; m_err = 1'b0;
    end else begin
      if (ext_en && m_holder >= 0 && u_if.req[m_holder]) m_err = 1'b1;
      if (m_holder >= 0) begin
        if (u_if.req[m_holder]) m_beats++;
        if (!u_if.req[m_holder] || m_beats == MH) begin
          m_rr     = (m_holder + 1) % N;
          m_holder = -1;
          arm();
        end
      end else if (m_next >= 0) begin
        m_gap--;
        if (m_gap <= 0) take();
      end else begin
        arm();
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Undriven bus reads as Z in a 4-state simulator and 0 in a 2-state one;
  // every requester's data is nonzero so a driven bus is never mistaken.
  task automatic check_released(input string name);
    total++;
    if (!($isunknown(bus) || bus == '0)) begin
      bad++;
      $display("FAIL %s: bus=%0h expected released (Z) at %0t", name, bus, $time);
    end
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (u_if.grant !== g && c < 20);
    total++;
    if (u_if.grant !== g) begin
      bad++;
      $display("FAIL %s: grant=%b expected %b within 20 cycles", name, u_if.grant, g);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [N-1:0] eg;
    bit ev;
    if (chk_en) begin
      eg = '0;
      if (m_holder >= 0) eg[m_holder] = 1'b1;
      ev = (m_holder >= 0) && u_if.req[m_holder];
      check("grant", u_if.grant, eg);
      check("grant_onehot0", $onehot0(u_if.grant), 1);
      check("owner_id", u_if.owner_id, m_last);
      check("bus_valid", u_if.bus_valid, ev);
      check("contention_err", u_if.contention_err, m_err);
      if (!ext_en) begin
        if (m_holder >= 0) check("bus", bus, u_if.wdata[m_holder*W +: W]);
        else               check_released("bus_z");
      end
    end
  end

  initial begin
    int seen[$];
    int exp_rr[5];
    logic [N-1:0] prev;
    int n;

    exp_rr = '{0, 1, 2, 3, 0};
    u_if.req   = '0;
    u_if.wdata = {8'hC3, 8'h5A, 8'hA5, 8'h3C};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_grant", u_if.grant, 0);
    check("rst_owner", u_if.owner_id, 0);
    check("rst_valid", u_if.bus_valid, 0);
    check_released("rst_bus");

    // 1: single request from IDLE
    @(posedge clk); #1;
    u_if.req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check("t1_turn_grant", u_if.grant, 0);
    check_released("t1_turn_bus");
    @(negedge clk);
    check("t1_grant", u_if.grant, 4'b0010);
    check("t1_owner", u_if.owner_id, 1);
    check("t1_bus", bus, 8'hA5);
    check("t1_valid", u_if.bus_valid, 1);
    @(posedge clk); #1;
    u_if.req = '0;
    repeat (4) @(posedge clk); #1;

    // 2: hold limit with a sole requester
    u_if.req = 4'b0001;
    wait_grant(4'b0001, "t2_first_grant");
    n = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (u_if.grant == 4'b0001) n++;
      else break;
    end
    check("t2_hold_beats", n, 4);
    check("t2_gap_grant", u_if.grant, 0);
    check_released("t2_gap_bus");
    @(negedge clk);
    check("t2_regrant", u_if.grant, 4'b0001);

    @(posedge clk); #1;
    u_if.req = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 3: round robin with all requesting
    u_if.req = 4'b1111;
    prev = '0;
    for (int c = 0; c < 60 && seen.size() < 5; c++) begin
      @(negedge clk);
      if (u_if.grant != '0 && prev == '0) seen.push_back(int'(u_if.owner_id));
      prev = u_if.grant;
    end
    check("t3_grants_seen", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      check($sformatf("t3_owner%0d", i), seen[i], exp_rr[i]);

    @(posedge clk); #1;
    u_if.req = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 4: early drop after two beats
    u_if.req = 4'b0100;
    wait_grant(4'b0100, "t4_grant");
    @(posedge clk); #1;
    @(posedge clk); #1;
    u_if.req = 4'b1001;
    @(negedge clk);
    check("t4_hold_grant", u_if.grant, 4'b0100);
    check("t4_hold_valid", u_if.bus_valid, 0);
    @(negedge clk);
    check("t4_gap_grant", u_if.grant, 0);
    check_released("t4_gap_bus");
    @(negedge clk);
    check("t4_next_grant", u_if.grant, 4'b1000);
    check("t4_next_owner", u_if.owner_id, 3);

    // 5: reset mid-OWN, with the pointer moved off zero beforehand
    @(posedge clk); #1;
    u_if.req = 4'b0010;
    wait_grant(4'b0010, "t5_warm_grant");
    @(posedge clk); #1;
    u_if.req = '0;
    repeat (3) @(posedge clk); #1;
    u_if.req = 4'b0010;
    wait_grant(4'b0010, "t5_grant");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    u_if.req = 4'b1001;
    @(negedge clk);
    check("t5_rst_grant", u_if.grant, 0);
    check("t5_rst_owner", u_if.owner_id, 0);
    check("t5_rst_valid", u_if.bus_valid, 0);
    check_released("t5_rst_bus");
    @(negedge clk);
    @(negedge clk);
    check("t5_rearb_grant", u_if.grant, 4'b0001);

    // 6: contention
    @(posedge clk); #1;
    u_if.req = '0;
    u_if.wdata[7:0] = 8'hFF;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    u_if.req = 4'b0001;
    wait_grant(4'b0001, "t6_grant");
`ifdef CONTENTION_CHK_EN
    @(posedge clk); #1;
    ext_en = 1'b1;
    @(posedge clk); #1;
    ext_en = 1'b0;
    @(negedge clk);
    check("t6_err_set", u_if.contention_err, 1);
    @(posedge clk); #1;
    u_if.req = '0;
    repeat (3) @(negedge clk);
    check("t6_err_sticky", u_if.contention_err, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_err_clear", u_if.contention_err, 0);
`else
    repeat (3) @(negedge clk);
    check("t6_no_chk", u_if.contention_err, 0);
    @(posedge clk); #1;
    u_if.req = '0;
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
